// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the RGB assembler.
//   lane_e  - direct-mode lane select encoding (switches input)
//   state_e - sequential-frame FSM states
//   put_lane - writes one byte lane of a shadow word (or clears it)
package rgb_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned RGB_W  = 3 * LANE_W;

    typedef enum logic [1:0] {
        LANE_B   = 2'b00,
        LANE_G   = 2'b01,
        LANE_R   = 2'b10,
        LANE_CLR = 2'b11
    } lane_e;

    typedef enum logic [2:0] {
        IDLE,
        GET0,
        GET1,
        GET2,
        COMMIT
    } state_e;

    function automatic logic [RGB_W-1:0] put_lane(input logic [RGB_W-1:0]  word,
                                                  input lane_e              lane,
                                                  input logic [LANE_W-1:0] data);
        logic [RGB_W-1:0] res;
        res = word;
        unique case (lane)
            LANE_B:   res[0*LANE_W +: LANE_W] = data;
            LANE_G:   res[1*LANE_W +: LANE_W] = data;
            LANE_R:   res[2*LANE_W +: LANE_W] = data;
            LANE_CLR: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rgb_timeout_cnt.sv
// rgb_timeout_cnt: idle-cycle counter for sequential frames.
//   clk, reset - clock and synchronous active-high reset
//   clear      - forces the count back to zero (has priority over enable)
//   enable     - advances the count by one per cycle until expired
//   expired    - high while the count sits at TIMEOUT_CYCLES-1
module rgb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    assign expired = (cnt_q == LastCnt);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/rgb_assembler.sv
// rgb_assembler: builds a 24-bit colour in a shadow register and commits it to rgb_out.
//   clk, reset  - clock and synchronous active-high reset
//   switches    - direct-mode lane select (B, G, R, clear)
//   channel_in  - data byte
//   load/commit - direct-mode write and copy strobes
//   seq_mode    - 1 selects the three-byte sequential protocol
//   byte_valid  - sequential-mode byte strobe
//   rgb_out     - committed colour; rgb_valid pulses on its first updated cycle
//   busy        - sequential frame in flight; lane_idx is the next lane expected
//   timeout_err - pulses once when a sequential frame is abandoned
module rgb_assembler import rgb_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        switches,
    input  logic [LANE_W-1:0] channel_in,
    input  logic              load,
    input  logic              commit,
    input  logic              seq_mode,
    input  logic              byte_valid,
    output logic [RGB_W-1:0]  rgb_out,
    output logic              rgb_valid,
    output logic              busy,
    output logic [1:0]        lane_idx,
    output logic              timeout_err
);

    state_e             state_q, state_d;
    logic [RGB_W-1:0]   shadow_q, shadow_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               valid_q, valid_d;
    logic               terr_q, terr_d;
    logic               accept;
    logic               counting;
    logic               expired;

    // GET0 holds a frame whose lane 0 arrived during COMMIT, so it waits for lane 1 just like
    // GET1 and is also covered by the timeout, otherwise such a frame could never be abandoned.
    rgb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept || !counting),
        .enable  (counting),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        rgb_d    = rgb_q;
        valid_d  = 1'b0;
        terr_d   = 1'b0;
        accept   = 1'b0;
        counting = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (seq_mode) begin
                    if (byte_valid) begin
                        shadow_d = put_lane(shadow_q, LANE_B, channel_in);
                        accept   = 1'b1;
                        state_d  = GET1;
                    end
                end else begin
                    if (load) begin
                        shadow_d = put_lane(shadow_q, lane_e'(switches), channel_in);
                    end
                    // Commit sees this cycle's load: copy the post-write shadow.
                    if (commit) begin
                        rgb_d   = shadow_d;
                        valid_d = 1'b1;
                    end
                end
            end
            GET0, GET1, GET2: begin
                counting = 1'b1;
                if (!seq_mode || (!byte_valid && expired)) begin
                    shadow_d = rgb_q;
                    terr_d   = 1'b1;
                    state_d  = IDLE;
                end else if (byte_valid) begin
                    accept = 1'b1;
                    if (state_q == GET2) begin
                        shadow_d = put_lane(shadow_q, LANE_R, channel_in);
                        state_d  = COMMIT;
                    end else begin
                        shadow_d = put_lane(shadow_q, LANE_G, channel_in);
                        state_d  = GET2;
                    end
                end
            end
            COMMIT: begin
                // rgb_out takes the completed frame; a byte arriving now starts the next one.
                rgb_d   = shadow_q;
                valid_d = 1'b1;
                state_d = IDLE;
                if (seq_mode && byte_valid) begin
                    shadow_d = put_lane(shadow_q, LANE_B, channel_in);
                    accept   = 1'b1;
                    state_d  = GET0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            rgb_q    <= '0;
            valid_q  <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            rgb_q    <= rgb_d;
            valid_q  <= valid_d;
            terr_q   <= terr_d;
        end
    end

    assign rgb_out     = rgb_q;
    assign rgb_valid   = valid_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q != IDLE);

    always_comb begin
        lane_idx = 2'b00;
        unique case (state_q)
            GET0, GET1: lane_idx = 2'b01;
            GET2:       lane_idx = 2'b10;
            default:    lane_idx = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_rgb_assembler.sv
module tb_rgb_assembler;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  switches = 2'b00;
    logic [7:0]  channel_in = 8'h00;
    logic        load = 1'b0;
    logic        commit = 1'b0;
    logic        seq_mode = 1'b0;
    logic        byte_valid = 1'b0;
    logic [23:0] rgb_out;
    logic        rgb_valid;
    logic        busy;
    logic [1:0]  lane_idx;
    logic        timeout_err;

    always #5 clk = ~clk;

    rgb_assembler #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .switches    (switches),
        .channel_in  (channel_in),
        .load        (load),
        .commit      (commit),
        .seq_mode    (seq_mode),
        .byte_valid  (byte_valid),
        .rgb_out     (rgb_out),
        .rgb_valid   (rgb_valid),
        .busy        (busy),
        .lane_idx    (lane_idx),
        .timeout_err (timeout_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the colour the user last committed, the shadow word, and the bytes
    // of the sequential frame received so far (a complete frame lands one cycle later).
    logic [23:0] m_rgb = '0;
    logic [23:0] m_shadow = '0;
    logic        m_valid = 1'b0;
    logic        m_terr = 1'b0;
    logic        m_pending = 1'b0;
    logic [7:0]  frame[$];
    int          m_idle = 0;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_abort();
        frame.delete();
        m_shadow = m_rgb;
        m_terr   = 1'b1;
        m_idle   = 0;
    endtask

    task automatic model_take_byte();
        m_shadow[8*frame.size() +: 8] = channel_in;
        frame.push_back(channel_in);
        m_idle = 0;
        if (frame.size() == 3) m_pending = 1'b1;
    endtask

    task automatic model_edge();
        m_valid = 1'b0;
        m_terr  = 1'b0;
        if (reset) begin
            m_rgb = '0;
            m_shadow = '0;
            frame.delete();
            m_pending = 1'b0;
            m_idle = 0;
        end else if (m_pending) begin
            m_rgb = {frame[2], frame[1], frame[0]};
            m_valid = 1'b1;
            m_pending = 1'b0;
            frame.delete();
            if (seq_mode && byte_valid) model_take_byte();
        end else if (frame.size() != 0) begin
            if (!seq_mode) begin
                model_abort();
            end else if (byte_valid) begin
                model_take_byte();
            end else begin
                m_idle++;
                if (m_idle == TO) model_abort();
            end
        end else if (seq_mode) begin
            if (byte_valid) model_take_byte();
        end else begin
            if (load) begin
                if (switches == 2'b11) m_shadow = '0;
                else m_shadow[8*switches +: 8] = channel_in;
            end
            if (commit) begin
                m_rgb = m_shadow;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] exp_lane;
        exp_lane = m_pending ? 2'b00 : 2'(frame.size());
        check({tag, "_rgb"}, rgb_out, m_rgb);
        check({tag, "_valid"}, {23'b0, rgb_valid}, {23'b0, m_valid});
        check({tag, "_busy"}, {23'b0, busy}, {23'b0, (frame.size() != 0)});
        check({tag, "_lane"}, {22'b0, lane_idx}, {22'b0, exp_lane});
        check({tag, "_terr"}, {23'b0, timeout_err}, {23'b0, m_terr});
    endtask

    task automatic drive(input string tag, input logic r, input logic [1:0] sw,
                         input logic [7:0] ch, input logic ld, input logic cm,
                         input logic sq, input logic bv);
        reset = r; switches = sw; channel_in = ch; load = ld; commit = cm;
        seq_mode = sq; byte_valid = bv;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int rate;
        logic sq_blk;

        // Reset state
        drive("rst0", 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rst1", 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_rgb_const", rgb_out, 24'h000000);

        // Direct lane loads then commit
        drive("d_ld0", 1'b0, 2'b00, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("d_ld1", 1'b0, 2'b01, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("d_ld2", 1'b0, 2'b10, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        check("d_hold_const", rgb_out, 24'h000000);
        drive("d_cm", 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("d_cm_const", rgb_out, 24'h332211);
        check("d_cm_valid_const", {23'b0, rgb_valid}, 24'd1);
        drive("d_after", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("d_after_valid_const", {23'b0, rgb_valid}, 24'd0);

        // Clear shadow, then load+commit in one cycle
        drive("d_clr", 1'b0, 2'b11, 8'h5a, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("d_ldcm", 1'b0, 2'b01, 8'haa, 1'b1, 1'b1, 1'b0, 1'b0);
        check("d_ldcm_const", rgb_out, 24'h00aa00);

        // byte_valid ignored in direct mode, load/commit ignored in sequential mode
        drive("d_bv", 1'b0, 2'b00, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        drive("s_ld", 1'b0, 2'b00, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0);

        // Sequential frame
        check("s_lane_idle_const", {22'b0, lane_idx}, 24'd0);
        drive("s_b0", 1'b0, 2'b00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        check("s_lane1_const", {22'b0, lane_idx}, 24'd1);
        drive("s_b1", 1'b0, 2'b00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
        check("s_lane2_const", {22'b0, lane_idx}, 24'd2);
        drive("s_b2", 1'b0, 2'b00, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1);
        check("s_b2_hold_const", rgb_out, 24'h00aa00);
        drive("s_cm", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("s_cm_const", rgb_out, 24'h030201);

        // Timeout after two bytes
        drive("t_b0", 1'b0, 2'b00, 8'hde, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("t_b1", 1'b0, 2'b00, 8'had, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < TO; i++) begin
            drive("t_wait", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("t_terr_const", {23'b0, timeout_err}, 24'd1);
        check("t_rgb_const", rgb_out, 24'h030201);
        drive("t_cm", 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t_shadow_const", rgb_out, 24'h030201);

        // seq_mode drop aborts a frame
        drive("a_b0", 1'b0, 2'b00, 8'hc1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("a_drop", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("a_terr_const", {23'b0, timeout_err}, 24'd1);

        // Back-to-back frames: byte during the commit cycle starts the next frame
        drive("bb_0", 1'b0, 2'b00, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("bb_1", 1'b0, 2'b00, 8'h20, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("bb_2", 1'b0, 2'b00, 8'h30, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("bb_3", 1'b0, 2'b00, 8'h40, 1'b0, 1'b0, 1'b1, 1'b1);
        check("bb_cm_const", rgb_out, 24'h302010);
        drive("bb_4", 1'b0, 2'b00, 8'h50, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("bb_5", 1'b0, 2'b00, 8'h60, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("bb_6", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bb_cm2_const", rgb_out, 24'h605040);

        // Reset in the middle of a frame, then a fresh frame
        drive("r_b0", 1'b0, 2'b00, 8'hf0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("r_b1", 1'b0, 2'b00, 8'hf1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("r_rst", 1'b1, 2'b00, 8'hf2, 1'b0, 1'b0, 1'b1, 1'b1);
        check("r_rgb_const", rgb_out, 24'h000000);
        check("r_busy_const", {23'b0, busy}, 24'd0);
        drive("r_f0", 1'b0, 2'b00, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("r_f1", 1'b0, 2'b00, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("r_f2", 1'b0, 2'b00, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("r_f3", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("r_frame_const", rgb_out, 24'h665544);

        // Randomized traffic in blocks with dense or sparse bytes
        rate = 70;
        sq_blk = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            if (i % 40 == 0) begin
                rate = ($urandom_range(0, 1) == 0) ? 80 : 8;
                sq_blk = ($urandom_range(0, 3) != 0);
            end
            drive("rnd",
                  ($urandom_range(0, 199) == 0),
                  2'($urandom_range(0, 3)),
                  8'($urandom),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) < 3) ? ~sq_blk : sq_blk,
                  ($urandom_range(0, 99) < rate));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_assembler.md
RGB_ASSEMBLER -- requirements
Module: rgb_assembler

Interface
REQ-001 The block SHALL take one parameter: TIMEOUT_CYCLES, default 1000, the maximum idle cycles between sequential-mode bytes before abort.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port switches, input, 2 bits: direct-mode lane select (00 = [7:0], 01 = [15:8], 10 = [23:16], 11 = clear).
REQ-005 The block SHALL have port channel_in, input, 8 bits: byte to write.
REQ-006 The block SHALL have port load, input, 1 bit: direct-mode write strobe.
REQ-007 The block SHALL have port commit, input, 1 bit: direct-mode strobe that copies the shadow register to the output.
REQ-008 The block SHALL have port seq_mode, input, 1 bit: 1 = sequential three-byte mode, 0 = direct mode.
REQ-009 The block SHALL have port byte_valid, input, 1 bit: sequential-mode byte strobe.
REQ-010 The block SHALL have port rgb_out, output, 24 bits: the committed color.
REQ-011 The block SHALL have port rgb_valid, output, 1 bit: one-cycle pulse that coincides with the first cycle of an updated rgb_out.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a sequential frame is in progress.
REQ-013 The block SHALL have port lane_idx, output, 2 bits: next lane expected in sequential mode; 00 when idle.
REQ-014 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a sequential frame is aborted.

Function
REQ-015 The block SHALL keep a 24-bit shadow register; rgb_out changes only on a commit.
REQ-016 Direct mode, load=1: at the clock edge the shadow lane selected by switches SHALL take channel_in; switches=11 SHALL clear the whole shadow to 0.
REQ-017 Direct mode, commit=1: rgb_out SHALL take the shadow at the edge, and rgb_valid SHALL be 1 during the following cycle.
REQ-018 Direct mode, load and commit in the same cycle: the commit SHALL include that cycle's load (write first, then copy).
REQ-019 In sequential mode, load and commit SHALL be ignored; in direct mode, byte_valid SHALL be ignored.
REQ-020 The FSM states SHALL be IDLE, GET0, GET1, GET2 and COMMIT.
REQ-021 FSM transitions:
- IDLE: on byte_valid with seq_mode=1, shadow[7:0] takes channel_in and the FSM goes to GET1.
- GET1: on byte_valid, write shadow[15:8] and go to GET2.
- GET2: on byte_valid, write shadow[23:16] and go to COMMIT.
- COMMIT: rgb_out takes the shadow, rgb_valid=1 in the next cycle, and the FSM returns to IDLE after one cycle.
- GET0 is entered only from COMMIT when byte_valid arrives in the COMMIT cycle; that byte SHALL be taken as lane 0 of the next frame.
REQ-022 busy SHALL be 1 in GET0, GET1, GET2 and COMMIT; lane_idx SHALL be 00, 01 or 10 according to the next expected lane.
REQ-023 A timeout counter SHALL reset on each accepted byte and count in GET1 and GET2; on reaching TIMEOUT_CYCLES-1 the block SHALL:
- return the FSM to IDLE;
- restore the shadow from rgb_out;
- pulse timeout_err for 1 cycle;
- leave rgb_out unchanged.
REQ-024 seq_mode falling while busy, in any state before COMMIT, SHALL abort exactly as a timeout does, including the timeout_err pulse.
REQ-025 Latency: from the third accepted byte to rgb_out updated SHALL be 2 edges; for a direct commit it SHALL be 1 edge.

Reset
REQ-026 On reset=1 at an edge:
- rgb_out, the shadow and the counter SHALL be 0;
- the FSM SHALL be IDLE;
- rgb_valid, busy, timeout_err and lane_idx SHALL be 0.
REQ-027 Reset mid-frame SHALL discard partial bytes with no rgb_valid and no timeout_err.

Structure
REQ-028 Package rgb_pkg SHALL hold the lane enum (LANE_B=00, LANE_G=01, LANE_R=10, LANE_CLR=11), the FSM state typedef, and the lane width of 8.
REQ-029 The timeout counter SHALL be the sub-module rgb_timeout_cnt (inputs clear and enable; output expired), sized $clog2(TIMEOUT_CYCLES).

Verification
REQ-030 Direct mode: load 0x11 on lane 00, 0x22 on lane 01, 0x33 on lane 10, then commit -> rgb_out=0x332211 and one rgb_valid pulse.
REQ-031 Direct mode: load 0xAA on lane 01 with commit in the same cycle, prior shadow 0 -> rgb_out=0x00AA00.
REQ-032 Sequential mode: bytes 0x01, 0x02, 0x03 -> rgb_out=0x030201 two edges after the last byte; busy is high for the frame; lane_idx steps 00, 01, 10.
REQ-033 Sequential mode, TIMEOUT_CYCLES=8: 2 bytes, then silence -> timeout_err pulse, rgb_out unchanged, shadow equal to rgb_out.
REQ-034 Reset asserted in GET2 -> all outputs 0 next cycle; a following full frame 0x44, 0x55, 0x66 -> rgb_out=0x665544.
